icache_fill_ctrl: RTL and testbench

L1 instruction-cache miss/fill controller (L1ICtrl). Accepts a miss from IFetch2, issues one line request to the memory side, and collects the response beats into a full cacheline. It then writes the line into the icache data array through that array's single-cycle fill port. It also handles flush: an outstanding refill is aborted cleanly and never writes a stale line.

---
 rtl/icache_fill_ctrl_pkg.sv | 43 ++++
 rtl/icache_fill_ctrl_if.sv | 28 ++
 rtl/icache_fill_buf.sv | 62 ++++++
 rtl/icache_fill_ctrl.sv | 140 ++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types and sizing for the L1 instruction-cache fill controller.
// Line, beat and address widths are derived here so every file agrees on them.
package icache_fill_ctrl_pkg;

    localparam int unsigned PADDR_W             = 32;
    localparam int unsigned CACHELINE_SIZE      = 16;
    localparam int unsigned CACHELINE_SIZE_BITS = 4;
    localparam int unsigned BEAT_BYTES          = 4;
    localparam int unsigned NUM_BEATS           = CACHELINE_SIZE / BEAT_BYTES;
    localparam int unsigned BEAT_PTR_W          = $clog2(NUM_BEATS);
    localparam int unsigned BEAT_OFF_BITS       = $clog2(BEAT_BYTES);
    localparam int unsigned BEAT_W              = 8 * BEAT_BYTES;

    typedef logic [PADDR_W-1:0]          paddr_t;
    typedef logic [8*CACHELINE_SIZE-1:0] icache_data_entry_t;
    typedef logic [BEAT_W-1:0]           beat_t;
    typedef logic [BEAT_PTR_W-1:0]       beat_ptr_t;
    typedef logic [BEAT_PTR_W:0]         beat_cnt_t;

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(NUM_BEATS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRecv,
        StFill,
        StDrain
    } ifill_state_t;

    function automatic paddr_t line_align(input paddr_t a);
        return a & ~paddr_t'(CACHELINE_SIZE - 1);
    endfunction

    function automatic paddr_t beat_align(input paddr_t a);
        return a & ~paddr_t'(BEAT_BYTES - 1);
    endfunction

    // Beat slot within the line that holds the byte at address a.
    function automatic beat_ptr_t beat_index(input paddr_t a);
        return a[CACHELINE_SIZE_BITS-1:BEAT_OFF_BITS];
    endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Memory-side channel of the icache fill controller: one line request out,
// response beats back with no backpressure.
interface icache_fill_ctrl_if;
    import icache_fill_ctrl_pkg::*;

    logic   mem_req_valid;
    logic   mem_req_ready;
    paddr_t mem_req_paddr;
    logic   mem_resp_valid;
    beat_t  mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_paddr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_paddr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

endinterface

// File: rtl/icache_fill_buf.sv
// Line assembly buffer: wrapping beat pointer, received-beat counter and one
// write-enabled slot register per beat.
module icache_fill_buf
    import icache_fill_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  beat_ptr_t          i_start_ptr,
    input  logic               i_count,
    input  logic               i_store,
    input  beat_t              i_beat,
    output beat_cnt_t          o_beat_cnt,
    output icache_data_entry_t o_line
);

    beat_ptr_t            beat_ptr_q;
    beat_cnt_t            beat_cnt_q;
    beat_t                line_q [NUM_BEATS];
    logic [NUM_BEATS-1:0] slot_we;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_ptr_q <= '0;
            beat_cnt_q <= '0;
        end else if (i_start) begin
            beat_ptr_q <= i_start_ptr;
            beat_cnt_q <= '0;
        end else if (i_count) begin
            beat_ptr_q <= beat_ptr_q + 1'b1;
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    always_comb begin
        slot_we = '0;
        if (i_store) begin
            slot_we[beat_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < NUM_BEATS; k++) begin
            if (i_rst) begin
                line_q[k] <= '0;
            end else if (slot_we[k]) begin
                line_q[k] <= i_beat;
            end
        end
    end

    // Slot k lands at byte offset k*BEAT_BYTES of the line.
    always_comb begin
        o_line = '0;
        for (int unsigned k = 0; k < NUM_BEATS; k++) begin
            o_line[k*BEAT_W +: BEAT_W] = line_q[k];
        end
    end

    assign o_beat_cnt = beat_cnt_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// L1 icache miss/fill controller: one line request per miss, beat collection, single-cycle fill,
// clean flush abort. Optional critical-word-first build: ICACHE_CRITICAL_WORD_FIRST_EN.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_miss,
    input  paddr_t             i_miss_paddr,
    output logic               o_miss_ack,
    output logic               o_busy,
    icache_fill_ctrl_if.master mem,
    output logic               o_fill,
    output paddr_t             o_fill_paddr,
    output icache_data_entry_t o_fill_data,
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    output logic               o_fill_done,
    output logic               o_crit_valid,
    output beat_t              o_crit_data
`else
    output logic               o_fill_done
`endif
);

    ifill_state_t state_q, state_d;
    paddr_t       paddr_q;
    beat_cnt_t    beat_cnt;
    beat_ptr_t    start_ptr;
    logic         last_beat;
    logic         buf_start;
    logic         buf_count;
    logic         buf_store;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            paddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (o_miss_ack) begin
                paddr_q <= i_miss_paddr;
            end
        end
    end

    assign last_beat = mem.mem_resp_valid && (beat_cnt == LAST_BEAT);

    always_comb begin
        state_d           = state_q;
        o_miss_ack        = 1'b0;
        mem.mem_req_valid = 1'b0;
        o_fill            = 1'b0;
        buf_start         = 1'b0;
        buf_count         = 1'b0;
        buf_store         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_miss && !i_flush) begin
                    o_miss_ack = 1'b1;
                    buf_start  = 1'b1;
                    state_d    = StReq;
                end
            end
            StReq: begin
                // Withdrawing an unaccepted request is legal on this port.
                if (i_flush) begin
                    state_d = StIdle;
                end else begin
                    mem.mem_req_valid = 1'b1;
                    if (mem.mem_req_ready) begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                buf_count = mem.mem_resp_valid;
                buf_store = mem.mem_resp_valid;
                if (last_beat) begin
                    state_d = i_flush ? StIdle : StFill;
                end else if (i_flush) begin
                    state_d = StDrain;
                end
            end
            StFill: begin
                o_fill  = !i_flush;
                state_d = StIdle;
            end
            StDrain: begin
                // Beats already requested must still be swallowed; nothing is written.
                buf_count = mem.mem_resp_valid;
                if (last_beat) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (i_rst) begin
            o_miss_ack        = 1'b0;
            mem.mem_req_valid = 1'b0;
            o_fill            = 1'b0;
            buf_start         = 1'b0;
        end
    end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign start_ptr         = beat_index(i_miss_paddr);
    assign mem.mem_req_paddr = beat_align(paddr_q);
    assign o_crit_valid      = (state_q == StRecv) && mem.mem_resp_valid && (beat_cnt == '0)
                               && !i_flush && !i_rst;
    assign o_crit_data       = o_crit_valid ? mem.mem_resp_data : '0;
`else
    assign start_ptr         = '0;
    assign mem.mem_req_paddr = line_align(paddr_q);
`endif

    assign o_busy       = (state_q != StIdle);
    assign o_fill_done  = o_fill;
    assign o_fill_paddr = line_align(paddr_q);

    icache_fill_buf u_fill_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (buf_start),
        .i_start_ptr (start_ptr),
        .i_count     (buf_count),
        .i_store     (buf_store),
        .i_beat      (mem.mem_resp_data),
        .o_beat_cnt  (beat_cnt),
        .o_line      (o_fill_data)
    );

`ifndef SYNTHESIS
    // Beats outside RECV/DRAIN violate the memory protocol and are dropped.
    resp_only_when_expected : assert property (@(posedge i_clk) disable iff (i_rst)
        mem.mem_resp_valid |-> (state_q == StRecv || state_q == StDrain))
        else $error("icache_fill_ctrl: response beat outside RECV/DRAIN");
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: refill, stalls, flush corners, reset mid-refill,
// and critical-word-first when ICACHE_CRITICAL_WORD_FIRST_EN is defined.
module tb_icache_fill_ctrl;
    import icache_fill_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               miss = 1'b0;
    paddr_t             miss_paddr = '0;
    logic               miss_ack;
    logic               busy;
    logic               fill;
    logic               fill_done;
    paddr_t             fill_paddr;
    icache_data_entry_t fill_data;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic               crit_valid;
    beat_t              crit_data;
`endif

    int total = 0;
    int bad = 0;
    int fill_cnt = 0;
    int hs_cnt = 0;
    int val_cnt = 0;

    icache_fill_ctrl_if mif ();

    icache_fill_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_miss       (miss),
        .i_miss_paddr (miss_paddr),
        .o_miss_ack   (miss_ack),
        .o_busy       (busy),
        .mem          (mif),
        .o_fill       (fill),
        .o_fill_paddr (fill_paddr),
        .o_fill_data  (fill_data),
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        .o_fill_done  (fill_done),
        .o_crit_valid (crit_valid),
        .o_crit_data  (crit_data)
`else
        .o_fill_done  (fill_done)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change only at the falling edge; count events once they have settled.
    always @(negedge clk) begin
        #2;
        if (fill) fill_cnt++;
        if (mif.mem_req_valid) begin
            val_cnt++;
            if (mif.mem_req_ready) hs_cnt++;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        mif.mem_req_ready = 1'b0;
        mif.mem_resp_valid = 1'b0;
        mif.mem_resp_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        total++; if (miss_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", miss_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (mif.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", mif.mem_req_valid); end
        total++; if (mif.mem_req_paddr !== '0) begin bad++; $display("FAIL rst_req_paddr: got %h want 0", mif.mem_req_paddr); end
        total++; if (fill !== 1'b0) begin bad++; $display("FAIL rst_fill: got %b want 0", fill); end
        total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", fill_done); end
        total++; if (fill_paddr !== '0) begin bad++; $display("FAIL rst_fill_paddr: got %h want 0", fill_paddr); end
        total++; if (fill_data !== '0) begin bad++; $display("FAIL rst_fill_data: got %h want 0", fill_data); end
    endtask

    task automatic test_basic();
        int f0;
        paddr_t exp_req;
        icache_data_entry_t exp_line;
        f0 = fill_cnt;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        exp_req = 32'h1004;
        exp_line = {32'hA2, 32'hA1, 32'hA0, 32'hA3};
`else
        exp_req = 32'h1000;
        exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
`endif
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h1004; mif.mem_req_ready = 1'b1; #1;
        total++; if (miss_ack !== 1'b1) begin bad++; $display("FAIL basic_ack: got %b want 1", miss_ack); end
        @(negedge clk); #1;
        total++; if (miss_ack !== 1'b0) begin bad++; $display("FAIL basic_ack_busy: got %b want 0", miss_ack); end
        total++; if (mif.mem_req_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", mif.mem_req_valid); end
        total++; if (mif.mem_req_paddr !== exp_req) begin bad++; $display("FAIL basic_req_paddr: got %h want %h", mif.mem_req_paddr, exp_req); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); miss = 1'b0; mif.mem_resp_valid = 1'b1; mif.mem_resp_data = beat_t'(32'hA0 + k); #1;
            if (k == 3) begin
                total++; if (fill !== 1'b0) begin bad++; $display("FAIL basic_early_fill: got %b want 0", fill); end
            end
        end
        @(negedge clk); mif.mem_resp_valid = 1'b0; mif.mem_req_ready = 1'b0; #1;
        total++; if (fill !== 1'b1) begin bad++; $display("FAIL basic_fill: got %b want 1", fill); end
        total++; if (fill_done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", fill_done); end
        total++; if (fill_paddr !== 32'h1000) begin bad++; $display("FAIL basic_fill_paddr: got %h want 1000", fill_paddr); end
        total++; if (fill_data !== exp_line) begin bad++; $display("FAIL basic_data: got %h want %h", fill_data, exp_line); end
        @(negedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b want 0", busy); end
        total++; if (fill_data !== exp_line) begin bad++; $display("FAIL basic_data_hold: got %h want %h", fill_data, exp_line); end
        total++; if (fill_cnt - f0 !== 1) begin bad++; $display("FAIL basic_fill_count: got %0d want 1", fill_cnt - f0); end
    endtask

    task automatic test_stall_gapped();
        int f0, v0, h0;
        icache_data_entry_t exp_line;
        exp_line = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        f0 = fill_cnt;
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h3000; mif.mem_req_ready = 1'b0; #1;
        total++; if (miss_ack !== 1'b1) begin bad++; $display("FAIL stall_ack: got %b want 1", miss_ack); end
        @(negedge clk); miss = 1'b0; v0 = val_cnt; h0 = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (mif.mem_req_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_held: got %b want 1", mif.mem_req_valid); end
            @(negedge clk);
        end
        mif.mem_req_ready = 1'b1;
        @(negedge clk); mif.mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                repeat (2) begin
                    mif.mem_resp_valid = 1'b0; #1;
                    total++; if (busy !== 1'b1 || fill !== 1'b0) begin bad++; $display("FAIL stall_gap: got busy=%b fill=%b want busy=1 fill=0", busy, fill); end
                    @(negedge clk);
                end
            end
            mif.mem_resp_valid = 1'b1; mif.mem_resp_data = beat_t'(32'hC0 + k);
            @(negedge clk);
        end
        mif.mem_resp_valid = 1'b0; #1;
        total++; if (fill !== 1'b1) begin bad++; $display("FAIL stall_fill: got %b want 1", fill); end
        total++; if (fill_paddr !== 32'h3000) begin bad++; $display("FAIL stall_fill_paddr: got %h want 3000", fill_paddr); end
        total++; if (fill_data !== exp_line) begin bad++; $display("FAIL stall_data: got %h want %h", fill_data, exp_line); end
        @(negedge clk); #1;
        total++; if (val_cnt - v0 !== 4) begin bad++; $display("FAIL stall_valid_cycles: got %0d want 4", val_cnt - v0); end
        total++; if (hs_cnt - h0 !== 1) begin bad++; $display("FAIL stall_handshakes: got %0d want 1", hs_cnt - h0); end
        total++; if (fill_cnt - f0 !== 1) begin bad++; $display("FAIL stall_fill_count: got %0d want 1", fill_cnt - f0); end
    endtask

    task automatic test_flush_recv();
        int f0;
        icache_data_entry_t exp_line;
        exp_line = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        f0 = fill_cnt;
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h4000; mif.mem_req_ready = 1'b1; #1;
        total++; if (miss_ack !== 1'b1) begin bad++; $display("FAIL frecv_ack: got %b want 1", miss_ack); end
        @(negedge clk); miss = 1'b0;
        @(negedge clk); mif.mem_resp_valid = 1'b1; mif.mem_resp_data = 32'hD0;
        @(negedge clk); mif.mem_resp_data = 32'hD1;
        @(negedge clk); mif.mem_resp_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0; miss = 1'b1; miss_paddr = 32'h2000;
        mif.mem_resp_valid = 1'b1; mif.mem_resp_data = 32'hD2; #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL frecv_drain_busy: got %b want 1", busy); end
        total++; if (miss_ack !== 1'b0) begin bad++; $display("FAIL frecv_ack_in_drain: got %b want 0", miss_ack); end
        @(negedge clk); mif.mem_resp_data = 32'hD3;
        @(negedge clk); mif.mem_resp_valid = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frecv_idle: got %b want 0", busy); end
        total++; if (miss_ack !== 1'b1) begin bad++; $display("FAIL frecv_new_ack: got %b want 1", miss_ack); end
        total++; if (fill_cnt !== f0) begin bad++; $display("FAIL frecv_no_fill: got %0d want %0d", fill_cnt, f0); end
        @(negedge clk); miss = 1'b0; #1;
        total++; if (mif.mem_req_paddr !== 32'h2000) begin bad++; $display("FAIL frecv_req_paddr: got %h want 2000", mif.mem_req_paddr); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mif.mem_resp_valid = 1'b1; mif.mem_resp_data = beat_t'(32'hE0 + k);
        end
        @(negedge clk); mif.mem_resp_valid = 1'b0; #1;
        total++; if (fill !== 1'b1) begin bad++; $display("FAIL frecv_fill: got %b want 1", fill); end
        total++; if (fill_paddr !== 32'h2000) begin bad++; $display("FAIL frecv_fill_paddr: got %h want 2000", fill_paddr); end
        total++; if (fill_data !== exp_line) begin bad++; $display("FAIL frecv_data: got %h want %h", fill_data, exp_line); end
        @(negedge clk); #1;
        total++; if (fill_cnt - f0 !== 1) begin bad++; $display("FAIL frecv_fill_count: got %0d want 1", fill_cnt - f0); end
    endtask

    task automatic test_flush_last();
        int f0;
        f0 = fill_cnt;
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h5000; mif.mem_req_ready = 1'b1;
        @(negedge clk); miss = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mif.mem_resp_valid = 1'b1; mif.mem_resp_data = beat_t'(32'hF0 + k);
            flush = (k == 3);
        end
        @(negedge clk); mif.mem_resp_valid = 1'b0; flush = 1'b0; #1;
        total++; if (fill !== 1'b0 || fill_done !== 1'b0) begin bad++; $display("FAIL flast_fill: got fill=%b done=%b want 0", fill, fill_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flast_idle: got %b want 0", busy); end
        @(negedge clk); #1;
        total++; if (fill_cnt !== f0) begin bad++; $display("FAIL flast_fill_count: got %0d want %0d", fill_cnt, f0); end
    endtask

    task automatic test_flush_req();
        int h0;
        h0 = hs_cnt;
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h6000; mif.mem_req_ready = 1'b0;
        @(negedge clk); miss = 1'b0; #1;
        total++; if (mif.mem_req_valid !== 1'b1) begin bad++; $display("FAIL freq_valid: got %b want 1", mif.mem_req_valid); end
        @(negedge clk); flush = 1'b1; mif.mem_req_ready = 1'b1; #1;
        total++; if (mif.mem_req_valid !== 1'b0) begin bad++; $display("FAIL freq_drop: got %b want 0", mif.mem_req_valid); end
        @(negedge clk); flush = 1'b0; mif.mem_req_ready = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL freq_idle: got %b want 0", busy); end
        total++; if (hs_cnt !== h0) begin bad++; $display("FAIL freq_handshake: got %0d want %0d", hs_cnt, h0); end
    endtask

    task automatic test_flush_fill();
        int f0;
        f0 = fill_cnt;
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h8000; mif.mem_req_ready = 1'b1;
        @(negedge clk); miss = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mif.mem_resp_valid = 1'b1; mif.mem_resp_data = beat_t'(32'h11 + k);
        end
        @(negedge clk); mif.mem_resp_valid = 1'b0; flush = 1'b1; #1;
        total++; if (fill !== 1'b0 || fill_done !== 1'b0) begin bad++; $display("FAIL ffill_suppress: got fill=%b done=%b want 0", fill, fill_done); end
        @(negedge clk); flush = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ffill_idle: got %b want 0", busy); end
        total++; if (fill_cnt !== f0) begin bad++; $display("FAIL ffill_fill_count: got %0d want %0d", fill_cnt, f0); end
    endtask

    task automatic test_reset_recv();
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h7000; mif.mem_req_ready = 1'b1;
        @(negedge clk); miss = 1'b0;
        @(negedge clk); mif.mem_resp_valid = 1'b1; mif.mem_resp_data = 32'h21;
        @(negedge clk); mif.mem_resp_data = 32'h22;
        @(negedge clk); mif.mem_resp_valid = 1'b0; mif.mem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rrecv_busy: got %b want 0", busy); end
        total++; if (mif.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rrecv_valid: got %b want 0", mif.mem_req_valid); end
        total++; if (mif.mem_req_paddr !== '0) begin bad++; $display("FAIL rrecv_req_paddr: got %h want 0", mif.mem_req_paddr); end
        total++; if (fill !== 1'b0 || fill_done !== 1'b0) begin bad++; $display("FAIL rrecv_fill: got fill=%b done=%b want 0", fill, fill_done); end
        total++; if (fill_paddr !== '0) begin bad++; $display("FAIL rrecv_fill_paddr: got %h want 0", fill_paddr); end
        total++; if (fill_data !== '0) begin bad++; $display("FAIL rrecv_fill_data: got %h want 0", fill_data); end
    endtask

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    task automatic test_crit_word_first();
        icache_data_entry_t exp_line;
        exp_line = {32'hB0, 32'hB3, 32'hB2, 32'hB1};
        @(negedge clk); miss = 1'b1; miss_paddr = 32'h100C; mif.mem_req_ready = 1'b1;
        @(negedge clk); miss = 1'b0; #1;
        total++; if (mif.mem_req_paddr !== 32'h100C) begin bad++; $display("FAIL cwf_req_paddr: got %h want 100c", mif.mem_req_paddr); end
        @(negedge clk); mif.mem_resp_valid = 1'b1; mif.mem_resp_data = 32'hB0; #1;
        total++; if (crit_valid !== 1'b1) begin bad++; $display("FAIL cwf_crit_valid: got %b want 1", crit_valid); end
        total++; if (crit_data !== 32'hB0) begin bad++; $display("FAIL cwf_crit_data: got %h want b0", crit_data); end
        @(negedge clk); mif.mem_resp_data = 32'hB1; #1;
        total++; if (crit_valid !== 1'b0) begin bad++; $display("FAIL cwf_crit_pulse: got %b want 0", crit_valid); end
        @(negedge clk); mif.mem_resp_data = 32'hB2;
        @(negedge clk); mif.mem_resp_data = 32'hB3;
        @(negedge clk); mif.mem_resp_valid = 1'b0; mif.mem_req_ready = 1'b0; #1;
        total++; if (fill !== 1'b1) begin bad++; $display("FAIL cwf_fill: got %b want 1", fill); end
        total++; if (fill_paddr !== 32'h1000) begin bad++; $display("FAIL cwf_fill_paddr: got %h want 1000", fill_paddr); end
        total++; if (fill_data !== exp_line) begin bad++; $display("FAIL cwf_data: got %h want %h", fill_data, exp_line); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall_gapped();
        test_flush_recv();
        test_flush_last();
        test_flush_req();
        test_flush_fill();
        test_reset_recv();
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        test_crit_word_first();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
